motor_ramp_sequencer: RTL and testbench
=======================================

# motor_ramp_sequencer

Sequences the two H-bridge motor channels (A = back right, B = back left) that the PWM pin driver feeds. It accepts per-motor speed/direction commands and owns the 500 Hz PWM period counter. It ramps each channel's duty toward its target one step per PWM period and enforces decelerate-to-zero plus a dead interval before any direction reversal. The per-motor duty compare value, direction and enable go straight to the PWM/pin stage.

## Interface

Parameters:
- PERIOD, 200000, PWM period in CLK100MHZ cycles (2 ms); duty full scale.
- STEP, 5000, maximum duty change per period (2.5 %).
- DEAD_PERIODS, 10, whole periods with enable low between decel and reversal; must be ≥ 1.

Ports:
- CLK100MHZ  in  1  the only clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid & ready.
- cmd_motor  in  1  0 = A, 1 = B.
- cmd_dir  in  1  requested direction (1 = forward).
- cmd_duty  in  18  target duty in cycles; values > PERIOD clamp to PERIOD.
- period_tick  out  1  one-cycle pulse on the last cycle of each period.
- pwm_count  out  18  period counter, 0..PERIOD-1.
- duty_a / duty_b  out  18  compare value; the pin stage drives high while pwm_count < duty.
- dir_a / dir_b  out  1  bridge direction.
- en_a / en_b  out  1  bridge enable.
- busy  out  2  per motor: high when not in STOP and not settled at target.

## Operation

- Counter counts 0..PERIOD-1 and wraps; period_tick = (pwm_count == PERIOD-1).
- cmd_ready is 1 whenever reset is low.
  - An accepted command overwrites that motor's target {dir, duty} on the next cycle.
  - Both motors share one command port, so one command per cycle.
- Per-motor FSM. All state, duty, dir and en updates occur only on period_tick, so the pin stage never sees a mid-period change.
  - **STOP** (duty 0, en 0): if target duty > 0, load dir = target dir, set en = 1, go to RUN. Duty ramps on subsequent ticks.
  - **RUN** (en 1):
    - If target dir ≠ dir, go to DECEL.
    - Otherwise, if |target − duty| ≤ STEP, set duty = target; else move duty by STEP toward target.
    - If duty is 0 and target is 0, set en = 0 and go to STOP.
  - **DECEL** (en 1):
    - If target dir == dir again, go back to RUN; no tick is lost and the ramp proceeds that tick.
    - Otherwise duty = max(duty − STEP, 0). When the result is 0, set en = 0, clear the dead counter and go to DEAD.
  - **DEAD** (en 0, duty 0): increment the dead counter. On the tick where it reaches DEAD_PERIODS − 1:
    - if target duty > 0, go to RUN with dir = target dir and en = 1;
    - else go to STOP.
- A direction change requested in STOP or DEAD needs no extra dead time; the new dir is loaded on leaving that state.
- Width rules:
  - Duty arithmetic is unsigned 18-bit.
  - Subtraction saturates at 0; addition saturates at the clamped target.
  - No wrap-around is permitted.

## Timing

- Reset: pwm_count 0, period_tick 0, duty 0, dir 0, en 0, busy 0, both FSMs in STOP, targets 0, cmd_ready 0 while reset is high.
  - Reset mid-ramp drops en the next cycle, with no decel.
- Command accepted in cycle N: target is visible at N+1. The first output change occurs the cycle after the first period_tick at or after N+1.
  - A tick coincident with acceptance uses the old target.
- Full-scale ramp 0 → PERIOD with defaults: 40 ticks after entering RUN.
- Reversal from duty D: ceil(D/STEP) decel ticks, then DEAD_PERIODS ticks with en low, then RUN.
- Commands for A and B on consecutive cycles are both honoured at the same tick.

## Structure

- Shared package motor_pkg: the FSM state enum (STOP, RUN, DECEL, DEAD), the default PERIOD/STEP/DEAD_PERIODS constants, and the duty width (18).
- Sub-module motor_ramp_channel: one FSM plus duty/dir/en/dead-counter, instantiated twice.
- The top holds the period counter, command demux and busy.

## Test plan

Bench overrides: PERIOD = 100, STEP = 25, DEAD_PERIODS = 2.

- **Ramp up:** reset, then command A fwd duty 60.
  - STOP→RUN at tick 1 (en_a 1, duty 0).
  - duty_a 25, 50, 60 on ticks 2–4.
  - busy[0] then falls; B stays 0.
- **Reversal:** A at 60 fwd, command A rev 60.
  - duty_a 35, 10, 0 on ticks 1–3; en_a falls with 0.
  - Two dead ticks with en_a 0, then RUN with dir_a 0, en_a 1; duty_a 25, 50, 60 on the following ticks.
- **Abort during DECEL:** A at 100 fwd, command rev, then fwd again after one tick (duty 75).
  - Returns to RUN and ramps back to 100.
  - en_a never drops and no DEAD is entered.
- **Clamp and stop:** command B duty 250000.
  - Target clamps to 100; duty_b ramps to 100.
  - Command B duty 0: ramps down to 0, en_b 0, STOP.
- **Reset mid-operation:** reset pulse while A is at duty 50 in RUN.
  - Next cycle: duty_a 0, en_a 0, pwm_count 0, FSM in STOP.
- **Tick collision:** command A fwd 40 on the same cycle as period_tick.
  - No change at that tick; STOP→RUN at the next tick.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and defaults for the two-channel motor ramp sequencer.
package motor_pkg;

  localparam int DUTY_W           = 18;
  localparam int DEAD_W           = 16;
  localparam int DEF_PERIOD       = 200000;
  localparam int DEF_STEP         = 5000;
  localparam int DEF_DEAD_PERIODS = 10;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DECEL = 2'd2,
    ST_DEAD  = 2'd3
  } motor_state_e;

endpackage

// File: rtl/motor_ramp_channel.sv
// One H-bridge channel: ramps duty toward target one step per PWM period and
// inserts decel-to-zero plus a dead interval before any direction reversal.
module motor_ramp_channel
  import motor_pkg::*;
#(
  parameter int STEP         = DEF_STEP,
  parameter int DEAD_PERIODS = DEF_DEAD_PERIODS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic              tgt_dir_i,
  input  logic [DUTY_W-1:0] tgt_duty_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              dir_o,
  output logic              en_o,
  output logic              busy_o,
  output motor_state_e      state_o
);

  localparam logic [DUTY_W-1:0] STEP_W    = DUTY_W'(STEP);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_PERIODS - 1);

  motor_state_e      state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;
  logic              en_q, en_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic [DUTY_W-1:0] ramp, decel;

  // Both candidate next duties; the branches guarantee no wrap and no overshoot.
  always_comb begin
    if (tgt_duty_i > duty_q) begin
      ramp = ((tgt_duty_i - duty_q) <= STEP_W) ? tgt_duty_i : duty_q + STEP_W;
    end else begin
      ramp = ((duty_q - tgt_duty_i) <= STEP_W) ? tgt_duty_i : duty_q - STEP_W;
    end
    decel = (duty_q > STEP_W) ? duty_q - STEP_W : '0;
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    en_d    = en_q;
    dead_d  = dead_q;
    if (tick_i) begin
      unique case (state_q)
        ST_STOP: begin
          if (tgt_duty_i != '0) begin
            dir_d   = tgt_dir_i;
            en_d    = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN, ST_DECEL: begin
          if (tgt_dir_i != dir_q) begin
            duty_d = decel;
            if (decel == '0) begin
              en_d    = 1'b0;
              dead_d  = '0;
              state_d = ST_DEAD;
            end else begin
              state_d = ST_DECEL;
            end
          end else begin
            duty_d = ramp;
            if (ramp == '0 && tgt_duty_i == '0) begin
              en_d    = 1'b0;
              state_d = ST_STOP;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_DEAD: begin
          if (dead_q == DEAD_LAST) begin
            if (tgt_duty_i != '0) begin
              dir_d   = tgt_dir_i;
              en_d    = 1'b1;
              state_d = ST_RUN;
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
        default: state_d = ST_STOP;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_STOP;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      en_q    <= 1'b0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      dead_q  <= dead_d;
    end
  end

  assign duty_o  = duty_q;
  assign dir_o   = dir_q;
  assign en_o    = en_q;
  assign state_o = state_q;
  assign busy_o  = (state_q != ST_STOP) &&
                   !(state_q == ST_RUN && duty_q == tgt_duty_i && dir_q == tgt_dir_i);

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Two-channel motor sequencer: owns the PWM period counter, latches per-motor
// targets from the shared command port and drives two ramp channels.
module motor_ramp_sequencer
  import motor_pkg::*;
#(
  parameter int PERIOD       = DEF_PERIOD,
  parameter int STEP         = DEF_STEP,
  parameter int DEAD_PERIODS = DEF_DEAD_PERIODS
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_motor,
  input  logic              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  output logic              period_tick,
  output logic [DUTY_W-1:0] pwm_count,
  output logic [DUTY_W-1:0] duty_a,
  output logic [DUTY_W-1:0] duty_b,
  output logic              dir_a,
  output logic              dir_b,
  output logic              en_a,
  output logic              en_b,
  output logic [1:0]        busy,
  output motor_state_e      dbg_state_a,
  output motor_state_e      dbg_state_b
);

  localparam logic [DUTY_W-1:0] PERIOD_W = DUTY_W'(PERIOD);

  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] tgt_duty_a_q, tgt_duty_a_d, tgt_duty_b_q, tgt_duty_b_d;
  logic              tgt_dir_a_q, tgt_dir_a_d, tgt_dir_b_q, tgt_dir_b_d;
  logic [DUTY_W-1:0] duty_clamped;
  logic              accept;
  logic              busy_a, busy_b;

  assign period_tick = (cnt_q == PERIOD_W - 1'b1);
  assign pwm_count   = cnt_q;

  // A command transfers on any cycle with cmd_valid && cmd_ready; ready is
  // simply "not in reset", and the new target is visible one cycle later.
  assign cmd_ready    = !reset;
  assign accept       = cmd_valid && cmd_ready;
  assign duty_clamped = (cmd_duty > PERIOD_W) ? PERIOD_W : cmd_duty;

  always_comb begin
    cnt_d        = period_tick ? '0 : cnt_q + 1'b1;
    tgt_duty_a_d = tgt_duty_a_q;
    tgt_dir_a_d  = tgt_dir_a_q;
    tgt_duty_b_d = tgt_duty_b_q;
    tgt_dir_b_d  = tgt_dir_b_q;
    if (accept && !cmd_motor) begin
      tgt_duty_a_d = duty_clamped;
      tgt_dir_a_d  = cmd_dir;
    end
    if (accept && cmd_motor) begin
      tgt_duty_b_d = duty_clamped;
      tgt_dir_b_d  = cmd_dir;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      cnt_q        <= '0;
      tgt_duty_a_q <= '0;
      tgt_dir_a_q  <= 1'b0;
      tgt_duty_b_q <= '0;
      tgt_dir_b_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      tgt_duty_a_q <= tgt_duty_a_d;
      tgt_dir_a_q  <= tgt_dir_a_d;
      tgt_duty_b_q <= tgt_duty_b_d;
      tgt_dir_b_q  <= tgt_dir_b_d;
    end
  end

  motor_ramp_channel #(.STEP(STEP), .DEAD_PERIODS(DEAD_PERIODS)) u_chan_a (
    .clk_i      (CLK100MHZ),
    .rst_i      (reset),
    .tick_i     (period_tick),
    .tgt_dir_i  (tgt_dir_a_q),
    .tgt_duty_i (tgt_duty_a_q),
    .duty_o     (duty_a),
    .dir_o      (dir_a),
    .en_o       (en_a),
    .busy_o     (busy_a),
    .state_o    (dbg_state_a)
  );

  motor_ramp_channel #(.STEP(STEP), .DEAD_PERIODS(DEAD_PERIODS)) u_chan_b (
    .clk_i      (CLK100MHZ),
    .rst_i      (reset),
    .tick_i     (period_tick),
    .tgt_dir_i  (tgt_dir_b_q),
    .tgt_duty_i (tgt_duty_b_q),
    .duty_o     (duty_b),
    .dir_o      (dir_b),
    .en_o       (en_b),
    .busy_o     (busy_b),
    .state_o    (dbg_state_b)
  );

  assign busy = {busy_b, busy_a};

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer with small PERIOD/STEP/DEAD values.
module tb_motor_ramp_sequencer;
  import motor_pkg::*;

  localparam int P = 100;
  localparam int S = 25;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_motor = 1'b0;
  logic         cmd_dir = 1'b0;
  logic [17:0]  cmd_duty = '0;
  logic         cmd_ready;
  logic         period_tick;
  logic [17:0]  pwm_count;
  logic [17:0]  duty_a, duty_b;
  logic         dir_a, dir_b, en_a, en_b;
  logic [1:0]   busy;
  motor_state_e dbg_state_a, dbg_state_b;

  logic [19:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  motor_ramp_sequencer #(.PERIOD(P), .STEP(S), .DEAD_PERIODS(D)) dut (
    .CLK100MHZ   (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_motor   (cmd_motor),
    .cmd_dir     (cmd_dir),
    .cmd_duty    (cmd_duty),
    .period_tick (period_tick),
    .pwm_count   (pwm_count),
    .duty_a      (duty_a),
    .duty_b      (duty_b),
    .dir_a       (dir_a),
    .dir_b       (dir_b),
    .en_a        (en_a),
    .en_b        (en_b),
    .busy        (busy),
    .dbg_state_a (dbg_state_a),
    .dbg_state_b (dbg_state_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic send(input logic m, input logic d, input logic [17:0] duty);
    cmd_valid = 1'b1;
    cmd_motor = m;
    cmd_dir   = d;
    cmd_duty  = duty;
    step();
    cmd_valid = 1'b0;
  endtask

  // Advance to the cycle just after the next period tick (current cycle included).
  task automatic wait_tick();
    int n = 0;
    while (period_tick !== 1'b1 && n < 2 * P) begin
      step();
      n++;
    end
    chk("tick_seen", 32'(period_tick), 32'd1);
    step();
  endtask

  task automatic push(input logic en, input logic b, input logic [17:0] duty);
    exp_q.push_back({en, b, duty});
  endtask

  task automatic tick_pop(input logic m, input string tag);
    logic [19:0] e, o;
    wait_tick();
    e = exp_q.pop_front();
    o = m ? {en_b, busy[1], duty_b} : {en_a, busy[0], duty_a};
    chk(tag, 32'(o), 32'(e));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_count", 32'(pwm_count), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    chk("rst_a", 32'({en_a, dir_a, duty_a}), 32'd0);
    chk("rst_b", 32'({en_b, dir_b, duty_b}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state_a", 32'(dbg_state_a), 32'(ST_STOP));
    chk("rst_state_b", 32'(dbg_state_b), 32'(ST_STOP));
    reset = 1'b0;
    step();
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Ramp up A fwd 60
    push(1, 1, 0); push(1, 1, 25); push(1, 1, 50); push(1, 0, 60);
    send(0, 1, 60);
    tick_pop(0, "ramp_t1");
    chk("ramp_dir", 32'(dir_a), 32'd1);
    chk("ramp_state", 32'(dbg_state_a), 32'(ST_RUN));
    tick_pop(0, "ramp_t2");
    tick_pop(0, "ramp_t3");
    tick_pop(0, "ramp_t4");
    chk("ramp_busy", 32'(busy), 32'd0);
    chk("ramp_b_idle", 32'({en_b, duty_b}), 32'd0);

    // Reversal A rev 60
    push(1, 1, 35); push(1, 1, 10); push(0, 1, 0); push(0, 1, 0);
    push(1, 1, 0); push(1, 1, 25); push(1, 1, 50); push(1, 0, 60);
    send(0, 0, 60);
    tick_pop(0, "rev_t1");
    chk("rev_decel", 32'(dbg_state_a), 32'(ST_DECEL));
    tick_pop(0, "rev_t2");
    tick_pop(0, "rev_t3");
    chk("rev_dead1", 32'(dbg_state_a), 32'(ST_DEAD));
    tick_pop(0, "rev_t4");
    chk("rev_dead2", 32'(dbg_state_a), 32'(ST_DEAD));
    tick_pop(0, "rev_t5");
    chk("rev_run", 32'(dbg_state_a), 32'(ST_RUN));
    chk("rev_dir", 32'(dir_a), 32'd0);
    tick_pop(0, "rev_t6");
    tick_pop(0, "rev_t7");
    tick_pop(0, "rev_t8");

    // Abort during DECEL
    do_reset(2);
    push(1, 1, 0); push(1, 1, 25); push(1, 1, 50); push(1, 1, 75); push(1, 0, 100);
    send(0, 1, 100);
    for (int i = 0; i < 5; i++) tick_pop(0, "abort_up");
    push(1, 1, 75);
    send(0, 0, 100);
    tick_pop(0, "abort_decel");
    chk("abort_state_decel", 32'(dbg_state_a), 32'(ST_DECEL));
    push(1, 0, 100);
    send(0, 1, 100);
    tick_pop(0, "abort_back");
    chk("abort_state_run", 32'(dbg_state_a), 32'(ST_RUN));
    chk("abort_dir", 32'(dir_a), 32'd1);

    // Clamp and stop on B
    push(1, 1, 0); push(1, 1, 25); push(1, 1, 50); push(1, 1, 75); push(1, 0, 100);
    send(1, 1, 18'd250000);
    for (int i = 0; i < 5; i++) tick_pop(1, "clamp_up");
    push(1, 1, 75); push(1, 1, 50); push(1, 1, 25); push(0, 0, 0);
    send(1, 1, 0);
    for (int i = 0; i < 4; i++) tick_pop(1, "stop_down");
    chk("stop_state_b", 32'(dbg_state_b), 32'(ST_STOP));
    chk("stop_a_untouched", 32'({en_a, duty_a}), 32'({1'b1, 18'd100}));

    // Reset while A runs at 50
    do_reset(2);
    push(1, 1, 0); push(1, 1, 25); push(1, 1, 50);
    send(0, 1, 100);
    for (int i = 0; i < 3; i++) tick_pop(0, "pre_rst");
    repeat (10) step();
    reset = 1'b1;
    step();
    chk("midrst_a", 32'({en_a, duty_a}), 32'd0);
    chk("midrst_count", 32'(pwm_count), 32'd0);
    chk("midrst_state", 32'(dbg_state_a), 32'(ST_STOP));
    reset = 1'b0;
    step();

    // Command coincident with period_tick
    for (int n = 0; n < 2 * P && period_tick !== 1'b1; n++) step();
    chk("coll_tick", 32'(period_tick), 32'd1);
    send(0, 1, 40);
    chk("coll_no_change", 32'({en_a, duty_a}), 32'd0);
    chk("coll_state", 32'(dbg_state_a), 32'(ST_STOP));
    push(1, 1, 0); push(1, 1, 25); push(1, 0, 40);
    tick_pop(0, "coll_t1");
    chk("coll_run", 32'(dbg_state_a), 32'(ST_RUN));
    tick_pop(0, "coll_t2");
    tick_pop(0, "coll_t3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
